// File: rtl/spi_ram_burst.sv
// -----------------------------------------------------------------------------
// spi_ram_burst
// Parametrised single-port RAM that sits behind an SPI slave. It receives
// 2-bit commands plus a payload word from the SPI receive side and returns
// read data to the SPI transmit side with a one-cycle tx_valid strobe.
// Out-of-range addresses and data commands that have no loaded address
// raise a one-cycle cmd_err pulse.
//
// Compile option: RAM_AUTO_INC_EN
//   defined   - wr_addr / rd_addr advance after each accepted 01 / 11
//               command and wrap from MEM_DEPTH-1 to 0 (burst transfers).
//   undefined - addresses stay put until the next 00 / 10 command.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   {cmd[1:0], payload[DATA_WIDTH-1:0]}
//   rx_valid  in   din valid this cycle
//   dout      out  read data, holds until the next read
//   tx_valid  out  one-cycle pulse per 11 command
//   cmd_err   out  one-cycle pulse per illegal command
//   busy_wr   out  write address loaded
//   busy_rd   out  read address loaded
//
// Handshake: a command is consumed on every rising clk edge where
// rx_valid=1; there is no back-pressure. tx_valid/cmd_err are strobes valid
// for exactly the one cycle after the consuming edge and carry no ready.
// -----------------------------------------------------------------------------
module spi_ram_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  cmd_err,
  output logic                  busy_wr,
  output logic                  busy_rd
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  // Storage is not reset; name kept as "memory" for backdoor loading.
  logic [DATA_WIDTH-1:0] memory [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_wr_addr_ok;
  logic                  r_rd_addr_ok;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_tx_valid;
  logic                  r_cmd_err;

  cmd_t                  w_cmd;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_addr_in_range;
  logic                  w_wr_en;

  assign w_cmd     = cmd_t'(din[DATA_WIDTH+1:DATA_WIDTH]);
  assign w_payload = din[DATA_WIDTH-1:0];
  // Address is the truncated low part of the payload.
  assign w_addr    = w_payload[ADDR_WIDTH-1:0];
  // Compare at 32 bits so MEM_DEPTH == 2**ADDR_WIDTH does not overflow.
  assign w_addr_in_range = (32'(w_addr) < MEM_DEPTH);
  assign w_wr_en   = rx_valid && (w_cmd == CMD_WR_DATA) && r_wr_addr_ok;

`ifdef RAM_AUTO_INC_EN
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
  logic [ADDR_WIDTH-1:0] w_wr_next;
  logic [ADDR_WIDTH-1:0] w_rd_next;
  // Wrap at MEM_DEPTH-1, which need not be a power-of-two boundary.
  assign w_wr_next = (r_wr_addr == LP_LAST) ? '0 : r_wr_addr + 1'b1;
  assign w_rd_next = (r_rd_addr == LP_LAST) ? '0 : r_rd_addr + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      memory[r_wr_addr] <= w_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_wr_addr_ok <= 1'b0;
      r_rd_addr_ok <= 1'b0;
      r_dout       <= '0;
      r_tx_valid   <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      // Strobes default low so each accepted command yields one-cycle pulses.
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      if (rx_valid) begin
        case (w_cmd)
          CMD_WR_ADDR: begin
            if (w_addr_in_range) begin
              r_wr_addr    <= w_addr;
              r_wr_addr_ok <= 1'b1;
            end else begin
              r_wr_addr_ok <= 1'b0;
              r_cmd_err    <= 1'b1;
            end
          end
          CMD_WR_DATA: begin
            if (r_wr_addr_ok) begin
`ifdef RAM_AUTO_INC_EN
              r_wr_addr <= w_wr_next;
`endif
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
          CMD_RD_ADDR: begin
            if (w_addr_in_range) begin
              r_rd_addr    <= w_addr;
              r_rd_addr_ok <= 1'b1;
            end else begin
              r_rd_addr_ok <= 1'b0;
              r_cmd_err    <= 1'b1;
            end
          end
          CMD_RD_DATA: begin
            // A read always answers; without an address it returns zero
            // and flags the error alongside.
            r_tx_valid <= 1'b1;
            if (r_rd_addr_ok) begin
              r_dout <= memory[r_rd_addr];
`ifdef RAM_AUTO_INC_EN
              r_rd_addr <= w_rd_next;
`endif
            end else begin
              r_dout    <= '0;
              r_cmd_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;
  assign cmd_err  = r_cmd_err;
  assign busy_wr  = r_wr_addr_ok;
  assign busy_rd  = r_rd_addr_ok;

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Parametrised single-port RAM for the SPI slave datapath, successor to the fixed 256x8 RAM.
- Accepts the same 2-bit command plus payload words from the SPI receive side.
- Generalises data width and memory depth, and adds out-of-range/sequence error reporting.
- Auto-increment burst addressing is available as a compile option.
- Read data returns to the SPI transmit side with a tx_valid strobe.

Parameters:
- DATA_WIDTH, 8, width of memory word and of command payload.
- ADDR_WIDTH, 8, internal address register width; must be <= DATA_WIDTH.
- MEM_DEPTH, 256, number of words; must be <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DATA_WIDTH+2  command word. din[DATA_WIDTH+1:DATA_WIDTH] is cmd; din[DATA_WIDTH-1:0] is payload.
- rx_valid  in  1  din is valid this cycle.
- dout  out  DATA_WIDTH  read data.
- tx_valid  out  1  dout valid, one-cycle pulse.
- cmd_err  out  1  one-cycle pulse on an illegal command.
- busy_wr  out  1  write address is loaded.
- busy_rd  out  1  read address is loaded.

Behaviour:
- Reset (async, rst_n=0):
  - wr_addr=0, rd_addr=0, dout=0, tx_valid=0, cmd_err=0.
  - wr_addr_ok=0, rd_addr_ok=0, busy_wr=0, busy_rd=0.
  - Memory contents are not reset. The storage array is named memory for backdoor $readmemb.
- Commands are sampled only on rising clk with rx_valid=1. With rx_valid=0 nothing changes and tx_valid/cmd_err drop to 0.
- Address truncation: addr = payload[ADDR_WIDTH-1:0]. For reads, an address is in range when it is < MEM_DEPTH.
- cmd 00, write address:
  - In range: wr_addr<=addr, wr_addr_ok<=1.
  - Out of range: cmd_err pulse, wr_addr_ok<=0.
- cmd 01, write data:
  - If wr_addr_ok: memory[wr_addr]<=payload.
  - Else: write suppressed, cmd_err pulse.
- cmd 10, read address:
  - In range: rd_addr<=addr, rd_addr_ok<=1.
  - Out of range: cmd_err pulse, rd_addr_ok<=0.
- cmd 11, read data, payload ignored:
  - If rd_addr_ok: dout<=memory[rd_addr], tx_valid<=1 at the same edge. Data is visible the cycle after the command edge (latency 1).
  - Else: dout<=0, tx_valid<=1, cmd_err<=1.
- Strobes: tx_valid and cmd_err are high for exactly one cycle per accepted command. Back-to-back 11 commands give back-to-back pulses.
- dout holds its last value until the next read.
- busy_wr = wr_addr_ok, busy_rd = rd_addr_ok (registered flags).
- Reset mid-sequence clears both _ok flags. A following 01 or 11 without a new address flags cmd_err.
- Write and read address registers are independent; a write does not disturb rd_addr.
- Read-after-write to the same address on the next cycle returns the new data.

Optional Feature:
- Macro: RAM_AUTO_INC_EN.
- Defined:
  - After each accepted 01 write, wr_addr increments.
  - After each accepted 11 read, rd_addr increments.
  - Increment wraps from MEM_DEPTH-1 to 0.
  - This allows burst transfers after a single address command.
- Undefined: addresses are static until the next 00/10 command.

Test Plan:
- Backdoor load memory[2]=8'h33, then din={10,8'h02} followed by {11,xx} -> tx_valid=1, dout=8'h33 one cycle after the read edge, cmd_err=0.
- Frontdoor {00,8'hAA}, {01,8'hF0}, {10,8'hAA}, {11,xx} -> dout=8'hF0, tx_valid pulse exactly one cycle.
- After reset, {01,8'h55} without an address -> cmd_err=1 for one cycle, memory unchanged. {11,xx} -> dout=0, tx_valid=1, cmd_err=1.
- MEM_DEPTH=200, {00,8'hC8} -> cmd_err pulse, busy_wr=0. A following {01,8'h12} is rejected with cmd_err.
- RAM_AUTO_INC_EN, MEM_DEPTH=256:
  - {00,8'hFE} then writes 8'h01, 8'h02, 8'h03 -> memory[FE]=01, memory[FF]=02, memory[00]=03 (wrap).
  - {10,8'hFE} then three reads -> dout 01, 02, 03.
- rst_n pulsed low mid-burst (between two 11 commands) -> outputs zero immediately. The next {11,xx} -> cmd_err=1, dout=0.
